// File: rtl/adder_share_arbiter_if.sv
// Request/response/adder bundle for adder_share_arbiter.
// The slave side is the arbiter; the master side holds the requesters, response sink and the shared adder.
interface adder_share_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic [WIDTH:0]        add_s;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, add_s,
        input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, add_s,
        output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters.
// One transaction in flight: grant -> ISSUE (adder settles) -> RESP (held until rsp_ready).
module adder_share_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input logic                  clk,
    input logic                  rst,
    adder_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_sum_q, rsp_sum_d;

    logic             accept_ok;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             take;
    logic [NREQ-1:0]  req_ready_c;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Rotating priority search starting at ptr; NREQ is a power of 2 so IDW-bit add wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant_idx) begin
                sel_a = bus.req_a[k*WIDTH +: WIDTH];
                sel_b = bus.req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    // Reset forces req_ready low in the reset cycle itself.
    assign accept_ok = !rst && ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
    assign take      = accept_ok && grant_found;

    always_comb begin
        req_ready_c            = '0;
        req_ready_c[grant_idx] = take;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ISSUE: begin
                rsp_sum_d   = bus.add_s;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            add_a_d = sel_a;
            add_b_d = sel_b;
            id_d    = grant_idx;
            ptr_d   = grant_idx + IDW'(1);
            state_d = ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

endmodule
